// File: rtl/picomem_wb_bridge_pkg.sv
// Shared types and constants for the PicoMem-to-Wishbone bridge on the 0xC000_0000 window.
package picomem_wb_bridge_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StBus  = 2'd1,
      StDone = 2'd2
   } bridge_state_e;

   localparam logic [31:0] DEFAULT_ERR_RDATA = 32'hDEAD_BEEF;

   // Window-select bits are stripped; the same mask defines the PicoMem mux windows.
   localparam logic [31:0] PICOMEM_WINDOW_MASK = 32'h0FFF_FFFF;

endpackage

// File: rtl/picomem_wb_bridge_if.sv
// PicoMem slave-side request/response signals and classic Wishbone master signals.
interface picomem_wb_bridge_if;

   logic        mem_s_valid;
   logic        mem_s_ready;
   logic [31:0] mem_s_addr;
   logic [31:0] mem_s_wdata;
   logic [3:0]  mem_s_wstrb;
   logic [31:0] mem_s_rdata;

   logic        wb_cyc_o;
   logic        wb_stb_o;
   logic        wb_we_o;
   logic [31:0] wb_adr_o;
   logic [3:0]  wb_sel_o;
   logic [31:0] wb_dat_o;
   logic [31:0] wb_dat_i;
   logic        wb_ack_i;
   logic        wb_err_i;

   modport mem_slave (
      input  mem_s_valid, mem_s_addr, mem_s_wdata, mem_s_wstrb,
      output mem_s_ready, mem_s_rdata
   );

   modport mem_master (
      output mem_s_valid, mem_s_addr, mem_s_wdata, mem_s_wstrb,
      input  mem_s_ready, mem_s_rdata
   );

   modport wb_master (
      output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
      input  wb_dat_i, wb_ack_i, wb_err_i
   );

   modport wb_slave (
      input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
      output wb_dat_i, wb_ack_i, wb_err_i
   );

endinterface

// File: rtl/picomem_wb_timeout.sv
// Bus timeout down-counter: loads TIMEOUT_CYCLES-1, counts down while enabled,
// flags expiry at zero.
module picomem_wb_timeout #(
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic clk,
   input  logic reset,
   input  logic i_clr,
   input  logic i_load,
   input  logic i_en,
   output logic o_expired
);

   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= LOAD_VAL;
      end else if (i_en && (r_cnt != '0)) begin
         r_cnt <= r_cnt - CNT_W'(1);
      end
   end

   assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/picomem_wb_bridge.sv
// PicoMem slave to classic Wishbone B4 master with timeout, error reporting and
// a saturating error counter. All outputs are registered.
module picomem_wb_bridge
   import picomem_wb_bridge_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 256,
   parameter logic [31:0] ADDR_MASK      = PICOMEM_WINDOW_MASK,
   parameter logic [31:0] ERR_RDATA      = DEFAULT_ERR_RDATA
) (
   input  logic                       clk,
   input  logic                       reset,
   picomem_wb_bridge_if.mem_slave     mem,
   picomem_wb_bridge_if.wb_master     wb,
   output logic                       bus_error,
   output logic [7:0]                 error_count
);

   bridge_state_e r_state, w_state_nxt;

   logic        r_cyc,     w_cyc_nxt;
   logic        r_we,      w_we_nxt;
   logic [31:0] r_adr,     w_adr_nxt;
   logic [3:0]  r_sel,     w_sel_nxt;
   logic [31:0] r_dat,     w_dat_nxt;
   logic        r_ready,   w_ready_nxt;
   logic [31:0] r_rdata,   w_rdata_nxt;
   logic        r_bus_err, w_bus_err_nxt;
   logic [7:0]  r_err_cnt, w_err_cnt_nxt;

   logic w_to_clr;
   logic w_to_load;
   logic w_to_en;
   logic w_expired;

   picomem_wb_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk       (clk),
      .reset     (reset),
      .i_clr     (w_to_clr),
      .i_load    (w_to_load),
      .i_en      (w_to_en),
      .o_expired (w_expired)
   );

   always_comb begin
      w_state_nxt   = r_state;
      w_cyc_nxt     = r_cyc;
      w_we_nxt      = r_we;
      w_adr_nxt     = r_adr;
      w_sel_nxt     = r_sel;
      w_dat_nxt     = r_dat;
      w_ready_nxt   = 1'b0;
      w_rdata_nxt   = r_rdata;
      w_bus_err_nxt = 1'b0;
      w_to_clr      = 1'b0;
      w_to_load     = 1'b0;
      w_to_en       = 1'b0;

      unique case (r_state)
         StIdle: begin
            if (mem.mem_s_valid) begin
               w_state_nxt = StBus;
               w_cyc_nxt   = 1'b1;
               w_we_nxt    = |mem.mem_s_wstrb;
               w_sel_nxt   = (|mem.mem_s_wstrb) ? mem.mem_s_wstrb : 4'hF;
               w_adr_nxt   = mem.mem_s_addr & ADDR_MASK;
               w_dat_nxt   = mem.mem_s_wdata;
               w_to_load   = 1'b1;
            end
         end
         StBus: begin
            w_to_en = 1'b1;
            // err beats ack, and ack beats an expiry on the same edge
            if (wb.wb_err_i || (!wb.wb_ack_i && w_expired)) begin
               w_state_nxt   = StDone;
               w_cyc_nxt     = 1'b0;
               w_ready_nxt   = 1'b1;
               w_rdata_nxt   = r_we ? 32'h0 : ERR_RDATA;
               w_bus_err_nxt = 1'b1;
               w_to_clr      = 1'b1;
            end else if (wb.wb_ack_i) begin
               w_state_nxt = StDone;
               w_cyc_nxt   = 1'b0;
               w_ready_nxt = 1'b1;
               w_rdata_nxt = r_we ? 32'h0 : wb.wb_dat_i;
               w_to_clr    = 1'b1;
            end
         end
         StDone: begin
            // valid is ignored here so a late-dropping master cannot relaunch
            w_state_nxt = StIdle;
            w_rdata_nxt = 32'h0;
         end
         default: begin
            w_state_nxt = StIdle;
            w_cyc_nxt   = 1'b0;
            w_rdata_nxt = 32'h0;
         end
      endcase

      w_err_cnt_nxt = r_err_cnt;
      if (w_bus_err_nxt && (r_err_cnt != 8'hFF)) begin
         w_err_cnt_nxt = r_err_cnt + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= StIdle;
         r_cyc     <= 1'b0;
         r_we      <= 1'b0;
         r_adr     <= 32'h0;
         r_sel     <= 4'h0;
         r_dat     <= 32'h0;
         r_ready   <= 1'b0;
         r_rdata   <= 32'h0;
         r_bus_err <= 1'b0;
         r_err_cnt <= 8'h0;
      end else begin
         r_state   <= w_state_nxt;
         r_cyc     <= w_cyc_nxt;
         r_we      <= w_we_nxt;
         r_adr     <= w_adr_nxt;
         r_sel     <= w_sel_nxt;
         r_dat     <= w_dat_nxt;
         r_ready   <= w_ready_nxt;
         r_rdata   <= w_rdata_nxt;
         r_bus_err <= w_bus_err_nxt;
         r_err_cnt <= w_err_cnt_nxt;
      end
   end

   assign wb.wb_cyc_o    = r_cyc;
   assign wb.wb_stb_o    = r_cyc;
   assign wb.wb_we_o     = r_we;
   assign wb.wb_adr_o    = r_adr;
   assign wb.wb_sel_o    = r_sel;
   assign wb.wb_dat_o    = r_dat;
   assign mem.mem_s_ready = r_ready;
   assign mem.mem_s_rdata = r_rdata;
   assign bus_error      = r_bus_err;
   assign error_count    = r_err_cnt;

endmodule

// File: tb/tb_picomem_wb_bridge.sv
// Scoreboard bench for picomem_wb_bridge: directed transfers against a registered
// Wishbone slave model with programmable wait states and error response.
module tb_picomem_wb_bridge;

   logic       clk = 1'b0;
   logic       reset;
   logic       bus_error;
   logic [7:0] error_count;

   always #5 clk = ~clk;

   picomem_wb_bridge_if bus_if ();

   picomem_wb_bridge #(
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .mem         (bus_if),
      .wb          (bus_if),
      .bus_error   (bus_error),
      .error_count (error_count)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Wishbone slave: ack/err registered after wait_n extra cycles of stb
   int          wait_n   = 0;
   logic        use_err  = 1'b0;
   logic        slv_ack  = 1'b0;
   logic        slv_err  = 1'b0;
   logic        frc_ack  = 1'b0;
   int          wcnt     = 0;
   logic [31:0] slv_data = 32'h0;

   assign bus_if.wb_ack_i = slv_ack | frc_ack;
   assign bus_if.wb_err_i = slv_err;
   assign bus_if.wb_dat_i = slv_data;

   always @(posedge clk) begin
      if (bus_if.wb_cyc_o && bus_if.wb_stb_o && !slv_ack && !slv_err) begin
         if (wcnt >= wait_n) begin
            if (use_err) slv_err <= 1'b1;
            else         slv_ack <= 1'b1;
         end else begin
            wcnt <= wcnt + 1;
         end
      end else begin
         slv_ack <= 1'b0;
         slv_err <= 1'b0;
         wcnt    <= 0;
      end
   end

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } rsp_t;

   rsp_t        sb_q[$];
   rsp_t        mon_e;
   logic [31:0] exp_adr_v = 32'h0;
   logic [3:0]  exp_sel_v = 4'h0;
   logic        exp_we_v  = 1'b0;
   logic [31:0] exp_dat_v = 32'h0;
   int          stb_cycles = 0;

   always @(negedge clk) begin
      if (bus_if.mem_s_ready === 1'b1) begin
         if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_ready actual=1 required=0");
         end else begin
            mon_e = sb_q.pop_front();
            check("rdata", bus_if.mem_s_rdata, mon_e.rdata);
            check("bus_error", {31'b0, bus_error}, {31'b0, mon_e.err});
         end
      end else if (bus_error !== 1'b0) begin
         checks++;
         failures++;
         $display("FAIL stray_bus_error actual=%b required=0", bus_error);
      end
      if (bus_if.wb_stb_o === 1'b1) begin
         stb_cycles++;
         check("wb_ctl", {28'b0, bus_if.wb_cyc_o, bus_if.wb_we_o, 2'b0},
               {28'b0, 1'b1, exp_we_v, 2'b0});
         check("wb_sel", {28'b0, bus_if.wb_sel_o}, {28'b0, exp_sel_v});
         check("wb_adr", bus_if.wb_adr_o, exp_adr_v);
         check("wb_dat", bus_if.wb_dat_o, exp_dat_v);
      end
   end

   task automatic xfer(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                       input int wt, input logic err_mode, input logic [31:0] sdata,
                       input logic [31:0] exp_adr, input logic [3:0] exp_sel,
                       input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat,
                       input string tag);
      int   lat;
      logic got;
      repeat (2) @(posedge clk);
      @(negedge clk);
      wait_n    = wt;
      use_err   = err_mode;
      slv_data  = sdata;
      exp_adr_v = exp_adr;
      exp_sel_v = exp_sel;
      exp_we_v  = (wstrb != 4'h0);
      exp_dat_v = wdata;
      sb_q.push_back('{rdata: exp_rdata, err: exp_err});
      stb_cycles = 0;
      bus_if.mem_s_valid = 1'b1;
      bus_if.mem_s_addr  = addr;
      bus_if.mem_s_wdata = wdata;
      bus_if.mem_s_wstrb = wstrb;
      lat = 0;
      got = 1'b0;
      while (!got && lat < 200) begin
         @(posedge clk);
         lat++;
         #1;
         if (bus_if.mem_s_ready === 1'b1) got = 1'b1;
      end
      bus_if.mem_s_valid = 1'b0;
      check({tag, "_latency"}, lat, exp_lat);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset              = 1'b1;
      bus_if.mem_s_valid = 1'b0;
      bus_if.mem_s_addr  = 32'h0;
      bus_if.mem_s_wdata = 32'h0;
      bus_if.mem_s_wstrb = 4'h0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", {31'b0, bus_if.mem_s_ready}, 32'h0);
      check("rst_rdata", bus_if.mem_s_rdata, 32'h0);
      check("rst_cyc_stb_we", {29'b0, bus_if.wb_cyc_o, bus_if.wb_stb_o, bus_if.wb_we_o}, 32'h0);
      check("rst_adr", bus_if.wb_adr_o, 32'h0);
      check("rst_sel", {28'b0, bus_if.wb_sel_o}, 32'h0);
      check("rst_dat", bus_if.wb_dat_o, 32'h0);
      check("rst_err", {23'b0, bus_error, error_count}, 32'h0);
      @(negedge clk);
      reset = 1'b0;

      xfer(32'hC000_0010, 32'h0, 4'h0, 0, 1'b0, 32'h1234_5678,
           32'h0000_0010, 4'hF, 32'h1234_5678, 1'b0, 3, "rd_zero_wait");

      xfer(32'hC000_0104, 32'hAABB_CCDD, 4'b0010, 5, 1'b0, 32'h5555_5555,
           32'h0000_0104, 4'b0010, 32'h0, 1'b0, 8, "wr_wait");
      check("cnt_after_wr", {24'b0, error_count}, 32'd0);

      xfer(32'hC000_0020, 32'h0, 4'h0, 0, 1'b1, 32'h7777_7777,
           32'h0000_0020, 4'hF, 32'hDEAD_BEEF, 1'b1, 3, "rd_err");
      check("cnt_after_rd_err", {24'b0, error_count}, 32'd1);

      xfer(32'hC000_0030, 32'h1122_3344, 4'b1111, 2, 1'b1, 32'h7777_7777,
           32'h0000_0030, 4'b1111, 32'h0, 1'b1, 5, "wr_err");
      check("cnt_after_wr_err", {24'b0, error_count}, 32'd2);

      xfer(32'hC000_0040, 32'h0, 4'h0, 10000, 1'b0, 32'h0,
           32'h0000_0040, 4'hF, 32'hDEAD_BEEF, 1'b1, 17, "rd_timeout");
      check("timeout_stb_cycles", stb_cycles, 32'd16);
      check("cnt_after_timeout", {24'b0, error_count}, 32'd3);

      // stray ack while not in BUS must be ignored
      @(negedge clk);
      frc_ack = 1'b1;
      @(negedge clk);
      @(negedge clk);
      frc_ack = 1'b0;
      repeat (2) @(negedge clk);
      check("late_ack_cyc", {31'b0, bus_if.wb_cyc_o}, 32'h0);
      check("cnt_after_late_ack", {24'b0, error_count}, 32'd3);

      xfer(32'hC000_0050, 32'h0, 4'h0, 14, 1'b0, 32'hCAFE_F00D,
           32'h0000_0050, 4'hF, 32'hCAFE_F00D, 1'b0, 17, "race");
      check("cnt_after_race", {24'b0, error_count}, 32'd3);

      for (int i = 0; i < 260; i++) begin
         xfer(32'hC000_0060, 32'h0, 4'h0, 10000, 1'b0, 32'h0,
              32'h0000_0060, 4'hF, 32'hDEAD_BEEF, 1'b1, 17, "sat");
      end
      check("cnt_saturated", {24'b0, error_count}, 32'h0000_00FF);

      // reset while stb is high
      repeat (2) @(posedge clk);
      @(negedge clk);
      wait_n    = 10000;
      use_err   = 1'b0;
      exp_adr_v = 32'h0000_0070;
      exp_sel_v = 4'hF;
      exp_we_v  = 1'b0;
      exp_dat_v = 32'h0;
      bus_if.mem_s_valid = 1'b1;
      bus_if.mem_s_addr  = 32'hC000_0070;
      bus_if.mem_s_wdata = 32'h0;
      bus_if.mem_s_wstrb = 4'h0;
      repeat (3) @(posedge clk);
      #1;
      check("pre_reset_stb", {31'b0, bus_if.wb_stb_o}, 32'h1);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("mid_reset_cyc_stb_ready",
            {29'b0, bus_if.wb_cyc_o, bus_if.wb_stb_o, bus_if.mem_s_ready}, 32'h0);
      check("mid_reset_cnt", {24'b0, error_count}, 32'h0);
      bus_if.mem_s_valid = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;

      xfer(32'hC000_0080, 32'h0, 4'h0, 0, 1'b0, 32'h0BAD_F00D,
           32'h0000_0080, 4'hF, 32'h0BAD_F00D, 1'b0, 3, "rd_after_reset");
      check("cnt_after_reset_rd", {24'b0, error_count}, 32'h0);

      repeat (3) @(negedge clk);
      check("scoreboard_empty", sb_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
